conv_pool_scheduler: RTL and testbench

Parametrised mode scheduler for the convolution/pooling feature-map pipeline. It replaces the single-request conv/pool switch with four mechanisms:
- a queued timestep counter;
- a selectable drain policy with a watchdog;
- a built-in pooling-window address generator with valid/ready handshake;
- sticky error flags.

It sits between the input event FIFO/capture stage, the fast convolution engine, the memory arbiter, and the pooling unit.

---
 rtl/snn_interfaces_pkg.sv | 16 +
 rtl/timestep_request_queue.sv | 46 ++++
 rtl/conv_pool_scheduler.sv | 132 +++++++++++++
 tb/tb_conv_pool_scheduler.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_interfaces_pkg.sv
// Shared types and defaults for the SNN feature-map pipeline.
// Scheduler state encoding and default scheduler parameters.
package snn_interfaces_pkg;

    typedef enum logic [1:0] {
        CONV  = 2'd0,
        DRAIN = 2'd1,
        POOL  = 2'd2,
        PAUSE = 2'd3
    } sched_state_t;

    localparam int DEFAULT_POOL_SIZE      = 2;
    localparam int DEFAULT_TS_QUEUE_DEPTH = 4;
    localparam int DEFAULT_DRAIN_TIMEOUT  = 1024;

endpackage

// File: rtl/timestep_request_queue.sv
// Timestep request queue: rising-edge detect, saturating pending
// counter and sticky overflow flag.
module timestep_request_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sys_enable,
    input  logic                         sys_reset,
    input  logic                         timestep,
    input  logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         overflow
);

    localparam int PW = $clog2(DEPTH + 1);

    logic prev;
    logic rise;

    assign rise = timestep & ~prev & sys_enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else if (sys_reset) begin
            prev     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            // prev tracks even while disabled so re-enable sees no stale edge
            prev <= timestep;
            if (rise && !done) begin
                if (pending == PW'(DEPTH))
                    overflow <= 1'b1;
                else
                    pending <= pending + PW'(1);
            end else if (done && !rise) begin
                pending <= pending - PW'(1);
            end
        end
    end

endmodule

// File: rtl/conv_pool_scheduler.sv
// Conv/pool mode scheduler: drain policy with watchdog, queued
// timestep requests and inline raster pooling-window generator.
module conv_pool_scheduler
    import snn_interfaces_pkg::*;
#(
    parameter int COORD_BITS     = 8,
    parameter int IMG_WIDTH      = 32,
    parameter int IMG_HEIGHT     = 32,
    parameter int POOL_SIZE      = DEFAULT_POOL_SIZE,
    parameter int TS_QUEUE_DEPTH = DEFAULT_TS_QUEUE_DEPTH,
    parameter int DRAIN_FIFO     = 0,
    parameter int DRAIN_TIMEOUT  = DEFAULT_DRAIN_TIMEOUT
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  sys_enable,
    input  logic                                  sys_reset,
    input  logic                                  timestep,
    input  logic                                  conv_active,
    input  logic                                  conv_ready,
    input  logic                                  fifo_empty,
    input  logic                                  out_fifo_full,
    output logic                                  capture_hold,
    output logic                                  conv_or_pool,
    output logic [COORD_BITS-1:0]                 pool_x,
    output logic [COORD_BITS-1:0]                 pool_y,
    output logic                                  pool_valid,
    input  logic                                  pool_ready,
    output logic                                  timestep_done,
    output logic [$clog2(TS_QUEUE_DEPTH+1)-1:0]   pending_ts,
    output logic                                  ts_overflow,
    output logic                                  drain_timeout,
    output logic [1:0]                            sched_state
);

    localparam int OUT_W = IMG_WIDTH / POOL_SIZE;
    localparam int OUT_H = IMG_HEIGHT / POOL_SIZE;
    localparam int CW    = $clog2(DRAIN_TIMEOUT + 1);

    localparam logic [COORD_BITS-1:0] STEP   = COORD_BITS'(POOL_SIZE);
    localparam logic [COORD_BITS-1:0] LAST_X = COORD_BITS'((OUT_W - 1) * POOL_SIZE);
    localparam logic [COORD_BITS-1:0] LAST_Y = COORD_BITS'((OUT_H - 1) * POOL_SIZE);
    localparam logic [CW-1:0]         CNT_MAX = CW'(DRAIN_TIMEOUT - 1);

    sched_state_t state_q, state_d;
    logic [CW-1:0] drain_cnt;
    logic drain_exit;
    logic drain_expired;
    logic hs;
    logic last_col;
    logic sweep_end;

    assign pool_valid   = (state_q == POOL) && !out_fifo_full;
    assign conv_or_pool = (state_q == CONV) || (state_q == DRAIN);
    assign capture_hold = ((state_q == DRAIN) && (DRAIN_FIFO == 0))
                        || (state_q == POOL) || (state_q == PAUSE);
    assign sched_state  = state_q;

    assign drain_exit    = conv_ready && !conv_active
                         && ((DRAIN_FIFO == 0) || fifo_empty);
    assign drain_expired = (drain_cnt == CNT_MAX);
    assign hs            = pool_valid && pool_ready && sys_enable;
    assign last_col      = (pool_x == LAST_X);
    assign sweep_end     = hs && last_col && (pool_y == LAST_Y);

    timestep_request_queue #(
        .DEPTH(TS_QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .sys_enable(sys_enable),
        .sys_reset (sys_reset),
        .timestep  (timestep),
        .done      (sweep_end),
        .pending   (pending_ts),
        .overflow  (ts_overflow)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CONV:  if (pending_ts != '0) state_d = DRAIN;
            DRAIN: if (drain_exit || drain_expired) state_d = POOL;
            POOL: begin
                if (out_fifo_full) state_d = PAUSE;
                else if (sweep_end) state_d = CONV;
            end
            PAUSE: if (!out_fifo_full) state_d = POOL;
            default: state_d = CONV;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CONV;
            drain_cnt     <= '0;
            drain_timeout <= 1'b0;
            pool_x        <= '0;
            pool_y        <= '0;
            timestep_done <= 1'b0;
        end else if (sys_reset) begin
            state_q       <= CONV;
            drain_cnt     <= '0;
            drain_timeout <= 1'b0;
            pool_x        <= '0;
            pool_y        <= '0;
            timestep_done <= 1'b0;
        end else if (sys_enable) begin
            state_q       <= state_d;
            timestep_done <= sweep_end;
            // counter sits at zero outside DRAIN, so DRAIN entry starts at 0
            if (state_q != DRAIN)
                drain_cnt <= '0;
            else
                drain_cnt <= drain_cnt + CW'(1);
            if ((state_q == DRAIN) && drain_expired && !drain_exit)
                drain_timeout <= 1'b1;
            if (sweep_end) begin
                pool_x <= '0;
                pool_y <= '0;
            end else if (hs) begin
                if (last_col) begin
                    pool_x <= '0;
                    pool_y <= pool_y + STEP;
                end else begin
                    pool_x <= pool_x + STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_pool_scheduler.sv
// Directed bench for conv_pool_scheduler: two 4x4 instances,
// one draining the FIFO, one freezing capture with a 16-cycle watchdog.
module tb_conv_pool_scheduler;

    localparam logic [1:0] S_CONV  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_POOL  = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sys_enable = 1'b1;
    logic sys_reset = 1'b0;
    logic timestep = 1'b0;
    logic conv_active = 1'b0;
    logic conv_ready = 1'b1;
    logic fifo_empty = 1'b1;
    logic out_fifo_full = 1'b0;
    logic pool_ready = 1'b1;

    logic       capture_hold, conv_or_pool, pool_valid, timestep_done;
    logic       ts_overflow, drain_timeout;
    logic [7:0] pool_x, pool_y;
    logic [2:0] pending_ts;
    logic [1:0] sched_state;

    logic       t_capture_hold, t_conv_or_pool, t_pool_valid, t_timestep_done;
    logic       t_ts_overflow, t_drain_timeout;
    logic [7:0] t_pool_x, t_pool_y;
    logic [2:0] t_pending_ts;
    logic [1:0] t_sched_state;

    int checks = 0;
    int errors = 0;

    localparam logic [26:0] RST_VEC = {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0};

    conv_pool_scheduler #(
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .POOL_SIZE(2),
        .TS_QUEUE_DEPTH(4), .DRAIN_FIFO(1), .DRAIN_TIMEOUT(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sys_enable(sys_enable), .sys_reset(sys_reset),
        .timestep(timestep), .conv_active(conv_active), .conv_ready(conv_ready),
        .fifo_empty(fifo_empty), .out_fifo_full(out_fifo_full),
        .capture_hold(capture_hold), .conv_or_pool(conv_or_pool),
        .pool_x(pool_x), .pool_y(pool_y), .pool_valid(pool_valid),
        .pool_ready(pool_ready), .timestep_done(timestep_done),
        .pending_ts(pending_ts), .ts_overflow(ts_overflow),
        .drain_timeout(drain_timeout), .sched_state(sched_state)
    );

    conv_pool_scheduler #(
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .POOL_SIZE(2),
        .TS_QUEUE_DEPTH(4), .DRAIN_FIFO(0), .DRAIN_TIMEOUT(16)
    ) dut_t (
        .clk(clk), .rst_n(rst_n), .sys_enable(sys_enable), .sys_reset(sys_reset),
        .timestep(timestep), .conv_active(conv_active), .conv_ready(conv_ready),
        .fifo_empty(fifo_empty), .out_fifo_full(out_fifo_full),
        .capture_hold(t_capture_hold), .conv_or_pool(t_conv_or_pool),
        .pool_x(t_pool_x), .pool_y(t_pool_y), .pool_valid(t_pool_valid),
        .pool_ready(pool_ready), .timestep_done(t_timestep_done),
        .pending_ts(t_pending_ts), .ts_overflow(t_ts_overflow),
        .drain_timeout(t_drain_timeout), .sched_state(t_sched_state)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_sys_reset;
        logic [26:0] obs;
        sys_reset = 1'b1;
        tick();
        sys_reset = 1'b0;
        obs = {sched_state, conv_or_pool, capture_hold, pool_valid, timestep_done,
               ts_overflow, drain_timeout, pending_ts, pool_x, pool_y};
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL sys_reset_a got %h want %h", obs, RST_VEC);
        end
        obs = {t_sched_state, t_conv_or_pool, t_capture_hold, t_pool_valid, t_timestep_done,
               t_ts_overflow, t_drain_timeout, t_pending_ts, t_pool_x, t_pool_y};
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL sys_reset_t got %h want %h", obs, RST_VEC);
        end
    endtask

    task automatic test_reset;
        logic [26:0] obs;
        #3;
        obs = {sched_state, conv_or_pool, capture_hold, pool_valid, timestep_done,
               ts_overflow, drain_timeout, pending_ts, pool_x, pool_y};
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL reset_a got %h want %h", obs, RST_VEC);
        end
        obs = {t_sched_state, t_conv_or_pool, t_capture_hold, t_pool_valid, t_timestep_done,
               t_ts_overflow, t_drain_timeout, t_pending_ts, t_pool_x, t_pool_y};
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL reset_t got %h want %h", obs, RST_VEC);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (sched_state !== S_CONV || pending_ts !== 3'd0) begin
            errors++;
            $display("FAIL idle_after_reset got st=%0d pend=%0d want st=0 pend=0", sched_state, pending_ts);
        end
    endtask

    task automatic test_sweep;
        int xs[4] = '{0, 2, 0, 2};
        int ys[4] = '{0, 0, 2, 2};
        timestep = 1'b1;
        tick();
        checks++;
        if (pending_ts !== 3'd1 || sched_state !== S_CONV) begin
            errors++;
            $display("FAIL edge_to_pending got pend=%0d st=%0d want 1 0", pending_ts, sched_state);
        end
        timestep = 1'b0;
        tick();
        checks++;
        if (sched_state !== S_DRAIN || conv_or_pool !== 1'b1 || capture_hold !== 1'b0) begin
            errors++;
            $display("FAIL drain_entry got st=%0d cop=%b ch=%b want 1 1 0", sched_state, conv_or_pool, capture_hold);
        end
        checks++;
        if (t_sched_state !== S_DRAIN || t_capture_hold !== 1'b1) begin
            errors++;
            $display("FAIL freeze_hold got st=%0d ch=%b want 1 1", t_sched_state, t_capture_hold);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (sched_state !== S_POOL || pool_valid !== 1'b1 || conv_or_pool !== 1'b0 ||
                pool_x !== 8'(xs[i]) || pool_y !== 8'(ys[i])) begin
                errors++;
                $display("FAIL origin_%0d got st=%0d v=%b (%0d,%0d) want st=2 v=1 (%0d,%0d)",
                         i, sched_state, pool_valid, pool_x, pool_y, xs[i], ys[i]);
            end
        end
        tick();
        checks++;
        if (sched_state !== S_CONV || timestep_done !== 1'b1 || pending_ts !== 3'd0 ||
            pool_x !== 8'd0 || pool_y !== 8'd0 || pool_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_done got st=%0d done=%b pend=%0d (%0d,%0d) want 0 1 0 (0,0)",
                     sched_state, timestep_done, pending_ts, pool_x, pool_y);
        end
        tick();
        checks++;
        if (timestep_done !== 1'b0 || sched_state !== S_CONV) begin
            errors++;
            $display("FAIL done_pulse_width got done=%b st=%0d want 0 0", timestep_done, sched_state);
        end
    endtask

    task automatic test_fifo_drain;
        fifo_empty = 1'b0;
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (sched_state !== S_DRAIN || capture_hold !== 1'b0) begin
                errors++;
                $display("FAIL fifo_drain_%0d got st=%0d ch=%b want 1 0", i, sched_state, capture_hold);
            end
            tick();
        end
        fifo_empty = 1'b1;
        tick();
        checks++;
        if (sched_state !== S_POOL || pool_valid !== 1'b1) begin
            errors++;
            $display("FAIL fifo_empty_exit got st=%0d v=%b want 2 1", sched_state, pool_valid);
        end
        repeat (5) tick();
        do_sys_reset();
    endtask

    task automatic test_timeout;
        conv_ready = 1'b0;
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        tick();
        checks++;
        if (t_sched_state !== S_DRAIN || t_capture_hold !== 1'b1) begin
            errors++;
            $display("FAIL wd_drain_entry got st=%0d ch=%b want 1 1", t_sched_state, t_capture_hold);
        end
        for (int i = 2; i <= 16; i++) begin
            tick();
            checks++;
            if (t_sched_state !== S_DRAIN || t_drain_timeout !== 1'b0) begin
                errors++;
                $display("FAIL wd_cycle_%0d got st=%0d to=%b want 1 0", i, t_sched_state, t_drain_timeout);
            end
        end
        tick();
        checks++;
        if (t_sched_state !== S_POOL || t_drain_timeout !== 1'b1 || t_pool_x !== 8'd0) begin
            errors++;
            $display("FAIL wd_fire got st=%0d to=%b x=%0d want 2 1 0", t_sched_state, t_drain_timeout, t_pool_x);
        end
        conv_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (t_sched_state !== S_CONV || t_timestep_done !== 1'b1 || t_drain_timeout !== 1'b1) begin
            errors++;
            $display("FAIL wd_sticky got st=%0d done=%b to=%b want 0 1 1",
                     t_sched_state, t_timestep_done, t_drain_timeout);
        end
        repeat (8) tick();
        do_sys_reset();
    endtask

    task automatic test_pause;
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (sched_state !== S_POOL || pool_x !== 8'd2 || pool_y !== 8'd0) begin
            errors++;
            $display("FAIL pause_setup got st=%0d (%0d,%0d) want 2 (2,0)", sched_state, pool_x, pool_y);
        end
        out_fifo_full = 1'b1;
        #1;
        checks++;
        if (pool_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_gates_valid got v=%b want 0", pool_valid);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (sched_state !== S_PAUSE || pool_valid !== 1'b0 || capture_hold !== 1'b1 ||
                pool_x !== 8'd2 || pool_y !== 8'd0) begin
                errors++;
                $display("FAIL pause_hold_%0d got st=%0d v=%b ch=%b (%0d,%0d) want 3 0 1 (2,0)",
                         i, sched_state, pool_valid, capture_hold, pool_x, pool_y);
            end
        end
        out_fifo_full = 1'b0;
        tick();
        checks++;
        if (sched_state !== S_POOL || pool_valid !== 1'b1 || pool_x !== 8'd2 || pool_y !== 8'd0) begin
            errors++;
            $display("FAIL pause_resume got st=%0d v=%b (%0d,%0d) want 2 1 (2,0)",
                     sched_state, pool_valid, pool_x, pool_y);
        end
        tick();
        checks++;
        if (pool_x !== 8'd0 || pool_y !== 8'd2) begin
            errors++;
            $display("FAIL pause_next got (%0d,%0d) want (0,2)", pool_x, pool_y);
        end
        tick();
        tick();
        checks++;
        if (timestep_done !== 1'b1 || sched_state !== S_CONV) begin
            errors++;
            $display("FAIL pause_done got done=%b st=%0d want 1 0", timestep_done, sched_state);
        end
        do_sys_reset();
    endtask

    task automatic test_overflow;
        int ndone;
        int first_t;
        int last_t;
        ndone = 0;
        first_t = -1;
        last_t = -1;
        conv_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            timestep = 1'b1;
            tick();
            timestep = 1'b0;
            tick();
        end
        checks++;
        if (pending_ts !== 3'd4 || ts_overflow !== 1'b1 || sched_state !== S_DRAIN) begin
            errors++;
            $display("FAIL overflow got pend=%0d ovf=%b st=%0d want 4 1 1", pending_ts, ts_overflow, sched_state);
        end
        conv_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (timestep_done === 1'b1) begin
                ndone++;
                if (first_t < 0) first_t = c;
                last_t = c;
            end
        end
        checks++;
        if (ndone != 4 || pending_ts !== 3'd0 || sched_state !== S_CONV) begin
            errors++;
            $display("FAIL queued_sweeps got n=%0d pend=%0d st=%0d want 4 0 0", ndone, pending_ts, sched_state);
        end
        checks++;
        if (first_t != 4 || last_t - first_t != 18) begin
            errors++;
            $display("FAIL sweep_spacing got first=%0d span=%0d want 4 18", first_t, last_t - first_t);
        end
        checks++;
        if (ts_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b want 1", ts_overflow);
        end
        do_sys_reset();
    endtask

    task automatic test_enable_gate;
        sys_enable = 1'b0;
        timestep = 1'b1;
        tick();
        tick();
        sys_enable = 1'b1;
        tick();
        tick();
        checks++;
        if (pending_ts !== 3'd0 || sched_state !== S_CONV) begin
            errors++;
            $display("FAIL disabled_edge got pend=%0d st=%0d want 0 0", pending_ts, sched_state);
        end
        timestep = 1'b0;
        tick();
    endtask

    task automatic test_async_reset;
        logic [26:0] obs;
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        obs = {sched_state, conv_or_pool, capture_hold, pool_valid, timestep_done,
               ts_overflow, drain_timeout, pending_ts, pool_x, pool_y};
        checks++;
        if (obs !== RST_VEC) begin
            errors++;
            $display("FAIL async_reset got %h want %h", obs, RST_VEC);
        end
        #2;
        rst_n = 1'b1;
        tick();
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        tick();
        tick();
        checks++;
        if (sched_state !== S_POOL || pool_x !== 8'd0 || pool_y !== 8'd0 || pool_valid !== 1'b1) begin
            errors++;
            $display("FAIL restart_origin got st=%0d v=%b (%0d,%0d) want 2 1 (0,0)",
                     sched_state, pool_valid, pool_x, pool_y);
        end
        repeat (4) tick();
        checks++;
        if (timestep_done !== 1'b1 || pending_ts !== 3'd0) begin
            errors++;
            $display("FAIL restart_done got done=%b pend=%0d want 1 0", timestep_done, pending_ts);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        do_sys_reset();
        test_fifo_drain();
        test_timeout();
        test_pause();
        test_overflow();
        test_enable_gate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
